// File: rtl/aes128_rsm_ctrl.sv
// Sequencer in front of the AES-128 RSM core: key register, plaintext FIFO,
// per-encryption key reload, LFSR mask rotation and held ciphertext output.
`timescale 1ns/1ps
module aes128_rsm_ctrl #(
    parameter int unsigned PT_DEPTH     = 2,
    parameter int unsigned TIMEOUT      = 31,
    parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] s_key,
    input  logic         s_key_valid,
    output logic         s_key_ready,
    input  logic [127:0] s_pt,
    input  logic         s_pt_valid,
    output logic         s_pt_ready,
    output logic [127:0] m_ct,
    output logic         m_ct_valid,
    input  logic         m_ct_ready,
    input  logic [15:0]  seed,
    input  logic         seed_load,
    output logic [127:0] core_key,
    output logic         core_key_valid,
    output logic [127:0] core_plaintext,
    output logic         core_plaintext_valid,
    output logic [3:0]   core_rotate,
    input  logic [127:0] core_ciphertext,
    input  logic         core_ciphertext_valid,
    input  logic         core_busy,
    output logic         busy,
    output logic         error,
    output logic [31:0]  enc_count
);
    localparam int unsigned PW = $clog2(PT_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(PT_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RELOAD, S_ISSUE, S_WAIT, S_OUT} state_e;

    state_e         state_q;
    logic [127:0]   key_q;
    logic [127:0]   mem_q [PT_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    count_q;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [TW-1:0]  timer_q;
    logic [127:0]   m_ct_q;
    logic           m_ct_valid_q, key_valid_q, pt_valid_q, error_q;
    logic [3:0]     rotate_q;
    logic [31:0]    enc_count_q;
    logic           fifo_empty, fifo_full, push, pop, key_fire;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign push       = s_pt_valid && !fifo_full;
    assign pop        = (state_q == S_ISSUE);
    assign key_fire   = s_key_valid && s_key_ready;

    // Fibonacci taps 16,14,13,11; feedback enters at bit 0
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    assign s_key_ready          = (state_q == S_IDLE) && fifo_empty;
    assign s_pt_ready           = !fifo_full;
    assign m_ct                 = m_ct_q;
    assign m_ct_valid           = m_ct_valid_q;
    assign core_key             = key_q;
    assign core_key_valid       = key_valid_q;
    assign core_plaintext       = mem_q[rd_ptr_q];
    assign core_plaintext_valid = pt_valid_q;
    assign core_rotate          = rotate_q;
    assign busy                 = (state_q != S_IDLE) || !fifo_empty;
    assign error                = error_q;
    assign enc_count            = enc_count_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_pt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lfsr_q       <= LFSR_DEFAULT;
            timer_q      <= '0;
            m_ct_q       <= '0;
            m_ct_valid_q <= 1'b0;
            key_valid_q  <= 1'b0;
            pt_valid_q   <= 1'b0;
            rotate_q     <= '0;
            error_q      <= 1'b0;
            enc_count_q  <= '0;
        end else begin
            key_valid_q <= 1'b0;
            pt_valid_q  <= 1'b0;
            if (key_fire) key_q <= s_key;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // Strobes and rotation are registered on entry to the state they belong to
            case (state_q)
                S_IDLE: begin
                    if (seed_load) lfsr_q <= (seed == '0) ? LFSR_DEFAULT : seed;
                    if (!fifo_empty && !core_busy) begin
                        state_q     <= S_RELOAD;
                        key_valid_q <= 1'b1;
                    end
                end
                S_RELOAD: begin
                    state_q    <= S_ISSUE;
                    pt_valid_q <= 1'b1;
                    rotate_q   <= lfsr_q[3:0];
                end
                S_ISSUE: begin
                    lfsr_q  <= lfsr_d;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_ciphertext_valid) begin
                        m_ct_q       <= core_ciphertext;
                        m_ct_valid_q <= 1'b1;
                        enc_count_q  <= enc_count_q + 32'd1;
                        state_q      <= S_OUT;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_OUT: begin
                    if (m_ct_ready) begin
                        m_ct_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes128_rsm_ctrl.md
Name: aes128_rsm_ctrl

Overview:
- Sequencer that sits directly upstream of the AES-128 RSM core.
- Accepts key and plaintext over valid/ready streams and buffers plaintexts in a small FIFO.
- Before every encryption it reloads the core round-key register, then issues the plaintext with a fresh LFSR-derived 4-bit mask rotation.
- Captures the ciphertext into a held output register with valid/ready; exactly one encryption is in flight at a time.

Parameters:
PT_DEPTH, 2, plaintext FIFO depth (power of two, >=2)
TIMEOUT, 31, max cycles in WAIT before abort
LFSR_DEFAULT, 16'hACE1, LFSR reset value and replacement for a zero seed

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
s_key  in  128  key
s_key_valid  in  1  key valid
s_key_ready  out  1  key accepted when valid&ready
s_pt  in  128  plaintext
s_pt_valid  in  1  plaintext valid
s_pt_ready  out  1  FIFO not full
m_ct  out  128  ciphertext
m_ct_valid  out  1  ciphertext valid
m_ct_ready  in  1  downstream ready
seed  in  16  LFSR seed
seed_load  in  1  load seed
core_key  out  128  to core key input; always = key register
core_key_valid  out  1  one-cycle core round-key reload
core_plaintext  out  128  FIFO head
core_plaintext_valid  out  1  one-cycle issue pulse
core_rotate  out  4  mask rotation offset
core_ciphertext  in  128  core result
core_ciphertext_valid  in  1  core result pulse
core_busy  in  1  core busy
busy  out  1  FSM not IDLE or FIFO non-empty
error  out  1  sticky timeout flag
enc_count  out  32  completed encryptions, wraps

Behaviour:
- Reset values: state IDLE; FIFO empty; key register 0; LFSR=LFSR_DEFAULT; m_ct=0; enc_count=0; error=0. All core_* strobes and m_ct_valid are 0.
- Reset asserted mid-operation aborts immediately. The in-flight result is discarded. A core_ciphertext_valid arriving later is ignored (FSM in IDLE).
- s_key_ready = (state==IDLE) & FIFO empty. A key accepted with s_key_valid&s_key_ready overwrites the key register on that edge.
- FIFO: write on s_pt_valid&s_pt_ready; pop on the ISSUE cycle.
  - Simultaneous push and pop when full is not possible, because ready is based on the registered full flag.
  - Pointers wrap modulo PT_DEPTH.
- FSM:
  - IDLE -> RELOAD when FIFO non-empty & !core_busy.
  - RELOAD (1 cycle): core_key_valid=1 -> ISSUE.
  - ISSUE (1 cycle): core_plaintext_valid=1; core_rotate=LFSR[3:0]; pop FIFO; advance LFSR -> WAIT.
  - WAIT: on core_ciphertext_valid, capture m_ct=core_ciphertext, set m_ct_valid, increment enc_count -> OUT. If the timer reaches TIMEOUT first: set error, go to IDLE, drop the result.
  - OUT: hold m_ct/m_ct_valid stable until m_ct_ready; on handshake clear m_ct_valid -> IDLE.
- core_rotate is held at the issued value from ISSUE until the next ISSUE, so the core samples a stable rotation.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. The feedback bit shifts in at bit 0. Advances only in ISSUE.
- seed_load is honoured only in IDLE; otherwise ignored. A seed of 0 loads LFSR_DEFAULT.
- WAIT timer resets to 0 on entry and increments each WAIT cycle.
- Latency: RELOAD runs on the cycle after a plaintext is accepted into an empty FIFO in IDLE. m_ct_valid rises 14 edges after the s_pt handshake edge.
- error is cleared only by reset.

Test Plan:
- FIPS-197: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> m_ct 69c4e0d86a7b0430d8cdb78070b4c55a; m_ct_valid rises at the 14th edge after the pt handshake; enc_count=1.
- Back-to-back: push same pt 3 times with m_ct_ready=1 -> three identical ciphertexts. core_key_valid pulses before each core_plaintext_valid, and s_pt_ready drops while FIFO holds 2.
- Backpressure: m_ct_ready=0 for 20 cycles -> m_ct held stable, no second ISSUE; FIFO fills and s_pt_ready=0; releasing m_ct_ready drains in order.
- LFSR: seed_load with seed=0 in IDLE -> LFSR=ACE1; first core_rotate=4'h1; a seed_load during WAIT is ignored.
- Timeout: tie core_ciphertext_valid=0 -> after 31 WAIT cycles error=1, FSM returns to IDLE, m_ct_valid stays 0, enc_count unchanged.
- Reset in WAIT -> next cycle all outputs at reset values. A subsequent core_ciphertext_valid pulse produces no m_ct_valid.
